// File: rtl/inj_stream_bridge.sv
// Purpose: host valid/ready flit stream -> credit-based rx/credit/data injector source port.
// Latency: 2 cycles from buffering to tx_o (cut-through) or from the last flit's write (store-and-forward).
// Backpressure: s_ready_o drops when the FIFO is full; credit_i low holds tx_o/data_o and pops nothing.

module inj_stream_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wr_en  = wr_vld && !full;
    assign rd_en  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module inj_stream_bridge #(
    parameter int FLIT_SIZE   = 32,
    parameter int DEPTH       = 16,
    parameter int CUT_THROUGH = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [FLIT_SIZE-1:0] s_data_i,
    input  logic                 s_last_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic [15:0]          pkt_sent_o,
    output logic                 oversize_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_SEND  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                go_force;
    logic                full;
    logic                empty;
    logic [FLIT_SIZE:0]  head;
    logic                head_last;
    logic                wr_last;
    logic                pop;
    logic                pop_last;
    logic [CW-1:0]       cpl_q;
    logic [15:0]         pkt_q;
    logic                oversize_q;

    inj_stream_fifo #(
        .W     (FLIT_SIZE + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_vld (s_valid_i),
        .wr_dat ({s_last_i, s_data_i}),
        .rd_rdy (pop),
        .full   (full),
        .empty  (empty),
        .rd_dat (head)
    );

    assign head_last  = head[FLIT_SIZE];
    assign s_ready_o  = !full;
    assign wr_last    = s_valid_i && !full && s_last_i;
    assign tx_o       = (state_q != ST_WAIT) && !empty;
    assign pop        = tx_o && credit_i;
    assign pop_last   = pop && head_last;
    assign data_o     = empty ? '0 : head[FLIT_SIZE-1:0];
    assign pkt_sent_o = pkt_q;
    assign oversize_o = oversize_q;

    // FORCE drains a packet too large to ever complete inside the FIFO.
    always_comb begin
        state_d  = state_q;
        go_force = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if ((CUT_THROUGH != 0) ? !empty : (cpl_q != '0)) begin
                    state_d = ST_SEND;
                end else if ((CUT_THROUGH == 0) && full && (cpl_q == '0)) begin
                    state_d  = ST_FORCE;
                    go_force = 1'b1;
                end
            end
            ST_SEND, ST_FORCE: begin
                if (pop_last) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_WAIT;
            cpl_q      <= '0;
            pkt_q      <= '0;
            oversize_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_last && !pop_last) begin
                cpl_q <= cpl_q + CW'(1);
            end else if (!wr_last && pop_last) begin
                cpl_q <= cpl_q - CW'(1);
            end
            if (pop_last) begin
                pkt_q <= pkt_q + 16'd1;
            end
            if (go_force) begin
                oversize_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inj_stream_bridge.sv
// Directed bench: store-and-forward instance plus a cut-through instance on a shared clock/reset.
module tb_inj_stream_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        sf_s_valid = 1'b0;
    logic        sf_s_ready;
    logic [31:0] sf_s_data = '0;
    logic        sf_s_last = 1'b0;
    logic        sf_tx;
    logic        sf_credit = 1'b1;
    logic [31:0] sf_data;
    logic [15:0] sf_pkt;
    logic        sf_ovs;

    logic        ct_s_valid = 1'b0;
    logic        ct_s_ready;
    logic [31:0] ct_s_data = '0;
    logic        ct_s_last = 1'b0;
    logic        ct_tx;
    logic        ct_credit = 1'b1;
    logic [31:0] ct_data;
    logic [15:0] ct_pkt;
    logic        ct_ovs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inj_stream_bridge #(.FLIT_SIZE(32), .DEPTH(16), .CUT_THROUGH(0)) dut_sf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .s_valid_i  (sf_s_valid),
        .s_ready_o  (sf_s_ready),
        .s_data_i   (sf_s_data),
        .s_last_i   (sf_s_last),
        .tx_o       (sf_tx),
        .credit_i   (sf_credit),
        .data_o     (sf_data),
        .pkt_sent_o (sf_pkt),
        .oversize_o (sf_ovs)
    );

    inj_stream_bridge #(.FLIT_SIZE(32), .DEPTH(16), .CUT_THROUGH(1)) dut_ct (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .s_valid_i  (ct_s_valid),
        .s_ready_o  (ct_s_ready),
        .s_data_i   (ct_s_data),
        .s_last_i   (ct_s_last),
        .tx_o       (ct_tx),
        .credit_i   (ct_credit),
        .data_o     (ct_data),
        .pkt_sent_o (ct_pkt),
        .oversize_o (ct_ovs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Streams an n-flit packet through the SF instance, checking every presented flit.
    // A flit held under credit_i=0 is rechecked each cycle, so it must stay stable.
    task automatic run_sf(input int n, input logic [31:0] base, input int wr_start,
                          input bit toggle, input string tag);
        int wr = wr_start;
        int rd = 0;
        int cyc = 0;
        while (rd < n && cyc < 200) begin
            sf_s_valid = (wr < n);
            sf_s_data  = base + 32'(wr);
            sf_s_last  = (wr == n - 1);
            sf_credit  = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (sf_s_valid && sf_s_ready) wr++;
            if (sf_tx) begin
                chk({tag, "_flit"}, sf_data, base + 32'(rd));
                if (sf_credit) rd++;
            end
            step();
            cyc++;
        end
        sf_s_valid = 1'b0;
        sf_s_last  = 1'b0;
        sf_credit  = 1'b1;
        chk({tag, "_all_delivered"}, 32'(rd), 32'(n));
    endtask

    initial begin
        int rd;
        int cyc;

        // Reset state
        #12;
        chk("rst_ready", sf_s_ready, 1);
        chk("rst_tx", sf_tx, 0);
        chk("rst_data", sf_data, 0);
        chk("rst_pkt", sf_pkt, 0);
        chk("rst_ovs", sf_ovs, 0);
        chk("rst_ct_tx", ct_tx, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // 1: SF three-flit packet, held until C arrives
        sf_s_valid = 1; sf_s_data = 32'hA; sf_s_last = 0;
        step();
        chk("t1_tx_after_A", sf_tx, 0);
        sf_s_data = 32'hB;
        step();
        chk("t1_tx_after_B", sf_tx, 0);
        sf_s_data = 32'hC; sf_s_last = 1;
        step();
        sf_s_valid = 0; sf_s_last = 0;
        chk("t1_tx_after_C", sf_tx, 0);
        step();
        chk("t1_tx_A", sf_tx, 1);
        chk("t1_data_A", sf_data, 32'hA);
        step();
        chk("t1_data_B", sf_data, 32'hB);
        step();
        chk("t1_tx_C", sf_tx, 1);
        chk("t1_data_C", sf_data, 32'hC);
        step();
        chk("t1_tx_idle", sf_tx, 0);
        chk("t1_pkt", sf_pkt, 1);

        // 2: cut-through single flit
        ct_s_valid = 1; ct_s_data = 32'hDEADBEEF; ct_s_last = 1;
        step();
        ct_s_valid = 0; ct_s_last = 0;
        chk("t2_tx_early", ct_tx, 0);
        step();
        chk("t2_tx", ct_tx, 1);
        chk("t2_data", ct_data, 32'hDEADBEEF);
        step();
        chk("t2_tx_after", ct_tx, 0);
        chk("t2_data_empty", ct_data, 0);
        chk("t2_pkt", ct_pkt, 1);
        chk("t2_ovs", ct_ovs, 0);

        // 3: SF 20-flit packet overflows into FORCE
        for (int i = 0; i < 16; i++) begin
            sf_s_valid = 1; sf_s_data = 32'h100 + 32'(i); sf_s_last = 0;
            step();
        end
        sf_s_valid = 0;
        chk("t3_ready_full", sf_s_ready, 0);
        chk("t3_tx_wait", sf_tx, 0);
        chk("t3_ovs_before", sf_ovs, 0);
        step();
        chk("t3_ovs", sf_ovs, 1);
        chk("t3_tx_force", sf_tx, 1);
        chk("t3_head", sf_data, 32'h100);
        run_sf(20, 32'h100, 16, 1'b0, "t3");
        chk("t3_pkt", sf_pkt, 2);
        chk("t3_tx_idle", sf_tx, 0);
        chk("t3_ovs_sticky", sf_ovs, 1);

        // 4: credit toggling during a 4-flit packet
        run_sf(4, 32'h400, 0, 1'b1, "t4");
        chk("t4_pkt", sf_pkt, 3);
        chk("t4_tx_idle", sf_tx, 0);
        chk("t4_ready", sf_s_ready, 1);

        // 5: fill with 16 single-flit packets while credit is withheld
        sf_credit = 0;
        for (int i = 0; i < 16; i++) begin
            sf_s_valid = 1; sf_s_data = 32'h500 + 32'(i); sf_s_last = 1;
            step();
        end
        sf_s_valid = 0; sf_s_last = 0;
        chk("t5_ready_full", sf_s_ready, 0);
        chk("t5_head_hold", sf_data, 32'h500);
        sf_credit = 1;
        rd = 0;
        cyc = 0;
        while (rd < 16 && cyc < 100) begin
            if (sf_tx) begin
                chk("t5_flit", sf_data, 32'h500 + 32'(rd));
                rd++;
            end
            step();
            cyc++;
        end
        chk("t5_all_delivered", 32'(rd), 16);
        chk("t5_cycles_one_idle_between", 32'(cyc), 31);
        chk("t5_pkt", sf_pkt, 19);
        chk("t5_ready_empty", sf_s_ready, 1);

        // 6: reset mid-packet
        for (int i = 0; i < 4; i++) begin
            sf_s_valid = 1; sf_s_data = 32'h600 + 32'(i); sf_s_last = (i == 3);
            step();
        end
        sf_s_valid = 0; sf_s_last = 0;
        step();
        chk("t6_data0", sf_data, 32'h600);
        step();
        step();
        chk("t6_data2", sf_data, 32'h602);
        chk("t6_tx_mid", sf_tx, 1);
        rst_n = 0;
        #1;
        chk("t6_rst_tx", sf_tx, 0);
        chk("t6_rst_data", sf_data, 0);
        chk("t6_rst_pkt", sf_pkt, 0);
        chk("t6_rst_ovs", sf_ovs, 0);
        chk("t6_rst_ready", sf_s_ready, 1);
        step();
        rst_n = 1;
        step();
        run_sf(2, 32'h700, 0, 1'b0, "t6");
        chk("t6_pkt", sf_pkt, 1);
        chk("t6_tx_idle", sf_tx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
